spi_mem_ctrl: RTL and testbench

- SPI master that serves every memory access requested by the control unit: instruction/operand fetch from the SPI flash (ROM), and read/write of the SPI SRAM (RAM).
- Sits directly between the CU handshake (spi_executing → start, done → spi_done) and the external SPI pins; rdata feeds the instruction register/bus (irin).
- Performs one single-byte transaction per request using standard 0x03 read / 0x02 write framing with 24-bit address.

---
 rtl/spi_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_spi_mem_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl.sv
// Single-byte SPI master for the CU: 0x03 reads from flash/SRAM and 0x02 writes to SRAM,
// each framed with a 24-bit address, one chip select active per transaction.
module spi_mem_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        rom_cs_n,
    output logic        ram_cs_n
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic        armed;
    logic        is_read;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [39:0] frame_sr;
    logic [7:0]  rx_sr;
    logic [39:0] frame_new;
    logic        accept;
    logic        tick;
    logic        rise;
    logic        fall;

    function automatic logic [39:0] build_frame(input logic [1:0] o, input logic [15:0] a,
                                                input logic [7:0] w);
        if (o == 2'd2)
            return {8'h02, 8'h00, a, w};
        return {8'h03, 8'h00, a, 8'h00};
    endfunction

    assign frame_new = build_frame(op, addr, wdata);
    assign accept    = (state == IDLE) && start && armed;
    assign tick      = (div_cnt == 8'd0);
    assign rise      = (state == SHIFT) && tick && !spi_sclk;
    assign fall      = (state == SHIFT) && tick && spi_sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            armed    <= 1'b1;
            is_read  <= 1'b0;
            div_cnt  <= 8'd0;
            bit_cnt  <= 6'd0;
            rdata    <= 8'h00;
            done     <= 1'b0;
            busy     <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            rom_cs_n <= 1'b1;
            ram_cs_n <= 1'b1;
        end else begin
            done <= 1'b0;
            // A held-high start must be seen low once before another request is taken
            if (!start)
                armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        armed   <= 1'b0;
                        busy    <= 1'b1;
                        is_read <= (op == 2'd0) || (op == 2'd1);
                        if (op == 2'd3) begin
                            state   <= HOLD;
                            div_cnt <= 8'd0;
                        end else begin
                            state    <= SHIFT;
                            div_cnt  <= DIV_LAST;
                            bit_cnt  <= 6'd0;
                            rom_cs_n <= (op != 2'd0);
                            ram_cs_n <= (op == 2'd0);
                            spi_mosi <= frame_new[39];
                        end
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        div_cnt <= DIV_LAST;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt == 6'd39) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 6'd1;
                                spi_mosi <= frame_sr[38];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rom_cs_n <= 1'b1;
                        ram_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        if (is_read)
                            rdata <= rx_sr;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift registers carry no control meaning, so they are left out of reset
    always_ff @(posedge clk) begin
        if (accept)
            frame_sr <= frame_new;
        else if (fall)
            frame_sr <= {frame_sr[38:0], 1'b0};
        if (rise)
            rx_sr <= {rx_sr[6:0], spi_miso};
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: one instance at CLK_DIV=2, one at CLK_DIV=1, each with an SPI slave model.
module tb_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;

    logic [7:0]  rdata_v [2];
    logic        done_v  [2];
    logic        busy_v  [2];
    logic        sclk_v  [2];
    logic        mosi_v  [2];
    logic        miso_v  [2] = '{1'b0, 1'b0};
    logic        rom_v   [2];
    logic        ram_v   [2];

    logic [7:0]  resp    [2] = '{8'h00, 8'h00};
    logic [39:0] mosi_sr [2] = '{40'h0, 40'h0};
    logic        sclk_prev [2] = '{1'b0, 1'b0};
    int          idx     [2] = '{0, 0};
    int          rises   [2] = '{0, 0};
    int          rom_lo  [2] = '{0, 0};
    int          ram_lo  [2] = '{0, 0};
    int          both_lo [2] = '{0, 0};
    int          dones   [2] = '{0, 0};

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_mem_ctrl #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[0]), .done(done_v[0]), .busy(busy_v[0]), .spi_sclk(sclk_v[0]),
        .spi_mosi(mosi_v[0]), .spi_miso(miso_v[0]), .rom_cs_n(rom_v[0]), .ram_cs_n(ram_v[0])
    );

    spi_mem_ctrl #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[1]), .done(done_v[1]), .busy(busy_v[1]), .spi_sclk(sclk_v[1]),
        .spi_mosi(mosi_v[1]), .spi_miso(miso_v[1]), .rom_cs_n(rom_v[1]), .ram_cs_n(ram_v[1])
    );

    // Slave model: captures mosi on sclk rise, presents resp MSB first on bits 32..39
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rom_v[i] === 1'b0 || ram_v[i] === 1'b0) begin
                if (!sclk_prev[i] && sclk_v[i] === 1'b1) begin
                    rises[i]++;
                    mosi_sr[i] = {mosi_sr[i][38:0], mosi_v[i]};
                end
                if (sclk_prev[i] && sclk_v[i] === 1'b0)
                    idx[i]++;
            end else begin
                idx[i] = 0;
            end
            if (rom_v[i] === 1'b0) rom_lo[i]++;
            if (ram_v[i] === 1'b0) ram_lo[i]++;
            if (rom_v[i] === 1'b0 && ram_v[i] === 1'b0) both_lo[i]++;
            if (done_v[i] === 1'b1) dones[i]++;
            sclk_prev[i] = (sclk_v[i] === 1'b1);
            miso_v[i] = (idx[i] >= 32 && idx[i] <= 39) ? resp[i][3'(39 - idx[i])] : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_txn(input int i, input logic [1:0] o, input logic [15:0] a,
                          input logic [7:0] w, input int lat, input bit hold_start,
                          input logic [39:0] exp_mosi, input logic [7:0] exp_rd);
        int c, r0, rom0, ram0, both0, d0;
        r0 = rises[i]; rom0 = rom_lo[i]; ram0 = ram_lo[i]; both0 = both_lo[i]; d0 = dones[i];
        op = o; addr = a; wdata = w; start = 1'b1;
        tick();
        chk("busy_at_accept", 40'(busy_v[i]), 40'd1);
        c = 0;
        do begin
            tick();
            c++;
        end while (done_v[i] !== 1'b1 && c < lat + 20);
        chk("done_latency", 40'(c), 40'(lat));
        chk("rdata", 40'(rdata_v[i]), 40'(exp_rd));
        if (!hold_start)
            start = 1'b0;
        tick();
        chk("done_one_cycle", 40'(done_v[i]), 40'd0);
        chk("busy_after", 40'(busy_v[i]), 40'd0);
        chk("sclk_rises", 40'(rises[i] - r0), (o == 2'd3) ? 40'd0 : 40'd40);
        chk("rom_cs_used", 40'(rom_lo[i] != rom0), 40'(o == 2'd0));
        chk("ram_cs_used", 40'(ram_lo[i] != ram0), 40'(o == 2'd1 || o == 2'd2));
        chk("both_cs_low", 40'(both_lo[i] - both0), 40'd0);
        chk("done_pulses", 40'(dones[i] - d0), 40'd1);
        if (o != 2'd3)
            chk("mosi_frame", mosi_sr[i], exp_mosi);
    endtask

    initial begin
        int c, r0, d0;
        rst = 1'b1; start = 1'b0; op = 2'd0; addr = 16'h0; wdata = 8'h0;
        repeat (3) tick();
        chk("rst_rdata", 40'(rdata_v[0]), 40'h0);
        chk("rst_done", 40'(done_v[0]), 40'h0);
        chk("rst_busy", 40'(busy_v[0]), 40'h0);
        chk("rst_sclk", 40'(sclk_v[0]), 40'h0);
        chk("rst_mosi", 40'(mosi_v[0]), 40'h0);
        chk("rst_rom_cs", 40'(rom_v[0]), 40'h1);
        chk("rst_ram_cs", 40'(ram_v[0]), 40'h1);
        rst = 1'b0;
        tick();

        // ROM read, then RAM write that must leave rdata alone
        resp[0] = 8'hA5;
        do_txn(0, 2'd0, 16'h1234, 8'h00, 162, 1'b0, 40'h0300123400, 8'hA5);
        do_txn(0, 2'd2, 16'h00FF, 8'h3C, 162, 1'b0, 40'h020000FF3C, 8'hA5);

        // start held high: exactly one transaction until it drops
        resp[0] = 8'h5A;
        do_txn(0, 2'd1, 16'h0040, 8'h00, 162, 1'b1, 40'h0300004000, 8'h5A);
        d0 = dones[0]; r0 = rises[0];
        repeat (300) tick();
        chk("held_no_done", 40'(dones[0] - d0), 40'd0);
        chk("held_no_sclk", 40'(rises[0] - r0), 40'd0);
        chk("held_busy", 40'(busy_v[0]), 40'd0);
        start = 1'b0;
        tick();
        resp[0] = 8'h96;
        do_txn(0, 2'd1, 16'h0041, 8'h00, 162, 1'b0, 40'h0300004100, 8'h96);

        // reset during bit 20 of a ROM read
        resp[0] = 8'hFF;
        r0 = rises[0]; d0 = dones[0];
        op = 2'd0; addr = 16'h2222; start = 1'b1;
        c = 0;
        while (rises[0] - r0 < 21 && c < 200) begin
            tick();
            c++;
        end
        chk("abort_reached_bit20", 40'(rises[0] - r0), 40'd21);
        rst = 1'b1; start = 1'b0;
        tick();
        chk("abort_rom_cs", 40'(rom_v[0]), 40'h1);
        chk("abort_ram_cs", 40'(ram_v[0]), 40'h1);
        chk("abort_sclk", 40'(sclk_v[0]), 40'h0);
        chk("abort_busy", 40'(busy_v[0]), 40'h0);
        rst = 1'b0;
        repeat (200) tick();
        chk("abort_no_done", 40'(dones[0] - d0), 40'd0);
        resp[0] = 8'h7E;
        do_txn(0, 2'd1, 16'h0001, 8'h00, 162, 1'b0, 40'h0300000100, 8'h7E);

        // reserved op: immediate done, no bus activity, rdata kept
        do_txn(0, 2'd3, 16'hBEEF, 8'h11, 1, 1'b0, 40'h0, 8'h7E);

        // CLK_DIV = 1, back-to-back ROM reads with CU handshake
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        resp[1] = 8'h11;
        do_txn(1, 2'd0, 16'h0000, 8'h00, 81, 1'b0, 40'h0300000000, 8'h11);
        resp[1] = 8'hC3;
        do_txn(1, 2'd0, 16'h0001, 8'h00, 81, 1'b0, 40'h0300000100, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
